// File: rtl/branch_sequencer.sv
// Program counter, S/Z/C flag register and taken-jump flush sequencer for the 16-bit core.
// Optional build macro BRANCH_FLAG_BYPASS_EN: jump condition uses same-cycle ALU flags when i_flag_we=1.
module branch_sequencer #(
    parameter int                PC_W         = 16,
    parameter logic [0:PC_W-1]   RESET_VEC    = '0,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_flag_we,
    input  logic [0:15]       i_alu_res,
    input  logic              i_alu_carry,
    input  logic              i_jmp_req,
    input  logic [0:5]        i_jCtrl,
    input  logic [0:PC_W-1]   i_jTarget,
    output logic [0:PC_W-1]   o_pc,
    output logic              o_pc_valid,
    output logic              o_flush,
    output logic              o_taken,
    output logic [0:2]        o_flags,
    output logic              o_fsm_state
);

    // Handshake: there is none; every input is sampled on each rising edge,
    // and i_stall only freezes the PC/FSM, never the flag register.

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [2:0]      CNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [0:PC_W-1] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [0:PC_W-1]   pc_q, pc_d;
    logic              taken_q, taken_d;
    logic [0:2]        flags_q;
    logic [0:2]        new_flags;
    logic [2:0]        sel;
    logic [0:7]        mask;
    logic              cond;

    assign new_flags = {i_alu_res[0], (i_alu_res == 16'h0000), i_alu_carry};

`ifdef BRANCH_FLAG_BYPASS_EN
    // Forward the flags being written this cycle so compare-then-branch resolves without a bubble.
    assign sel = i_flag_we ? {new_flags[0], new_flags[1], new_flags[2]}
                           : {flags_q[0], flags_q[1], flags_q[2]};
`else
    assign sel = {flags_q[0], flags_q[1], flags_q[2]};
`endif

    // Positions 6 and 7 of the mask are hard zero, so sel values 6/7 never jump.
    assign mask = {i_jCtrl, 2'b00};
    assign cond = mask[sel];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        case (state_q)
            RUN: begin
                if (!i_stall) begin
                    if (i_jmp_req && cond) begin
                        pc_d    = i_jTarget;
                        taken_d = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = FLUSH;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            FLUSH: begin
                // The exit edge leaves the PC on the target so it is fetched once valid.
                if (!i_stall) begin
                    if (cnt_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            pc_q    <= RESET_VEC;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flags_q <= 3'b000;
        end else if (i_flag_we) begin
            flags_q <= new_flags;
        end
    end

    assign o_pc        = pc_q;
    assign o_flush     = (state_q == FLUSH);
    assign o_pc_valid  = (state_q == RUN);
    assign o_taken     = taken_q;
    assign o_flags     = flags_q;
    assign o_fsm_state = state_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed and randomized bench for branch_sequencer against a cycle-level reference model.
// Follows BRANCH_FLAG_BYPASS_EN for the same-cycle flag/jump rule.
module tb_branch_sequencer;

    localparam int          FLUSH_CYCLES = 2;
    localparam logic [15:0] RESET_VEC    = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flag_we;
    logic [0:15] alu_res;
    logic        alu_carry;
    logic        jmp_req;
    logic [0:5]  jctrl;
    logic [0:15] jtarget;
    logic [0:15] pc;
    logic        pc_valid;
    logic        flush;
    logic        taken;
    logic [0:2]  flags;
    logic        fsm_state;

    // Reference model state: flush_rem counts non-stalled edges left before fetch resumes.
    logic [15:0] m_pc;
    logic [2:0]  m_flags;
    int          m_flush_rem;
    logic        m_taken;

    logic [15:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    branch_sequencer #(
        .PC_W(16), .RESET_VEC(RESET_VEC), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flag_we(flag_we),
        .i_alu_res(alu_res), .i_alu_carry(alu_carry), .i_jmp_req(jmp_req),
        .i_jCtrl(jctrl), .i_jTarget(jtarget), .o_pc(pc), .o_pc_valid(pc_valid),
        .o_flush(flush), .o_taken(taken), .o_flags(flags), .o_fsm_state(fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_pc        = RESET_VEC;
        m_flags     = 3'b000;
        m_flush_rem = 0;
        m_taken     = 1'b0;
    endtask

    task automatic model_edge();
        int  s;
        bit  c;
        logic [2:0] nf;
        nf = {alu_res[0], (alu_res == 16'h0000), alu_carry};
        s  = int'(m_flags);
`ifdef BRANCH_FLAG_BYPASS_EN
        if (flag_we) s = int'(nf);
`endif
        c = (s < 6) ? jctrl[s] : 1'b0;
        m_taken = 1'b0;
        if (m_flush_rem > 0) begin
            if (!stall) m_flush_rem = m_flush_rem - 1;
        end else if (!stall) begin
            if (jmp_req && c) begin
                m_pc        = jtarget;
                m_taken     = 1'b1;
                m_flush_rem = FLUSH_CYCLES;
            end else begin
                m_pc = m_pc + 16'd1;
            end
        end
        if (flag_we) m_flags = nf;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        exp_q.push_back(m_pc);
        chk({tag, "/pc"}, pc, exp_q.pop_front());
        chk({tag, "/flags"}, 16'(flags), 16'(m_flags));
        chk({tag, "/flush"}, 16'(flush), 16'(m_flush_rem > 0));
        chk({tag, "/valid"}, 16'(pc_valid), 16'(m_flush_rem == 0));
        chk({tag, "/taken"}, 16'(taken), 16'(m_taken));
        chk({tag, "/state"}, 16'(fsm_state), 16'(m_flush_rem > 0));
    endtask

    // driver tasks
    task automatic drive(input logic st, input logic we, input logic [15:0] res, input logic cy,
                         input logic jr, input logic [5:0] jc, input logic [15:0] tg);
        stall = st; flag_we = we; alu_res = res; alu_carry = cy;
        jmp_req = jr; jctrl = jc; jtarget = tg;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 6'b000000, 16'h0000);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // free-running increment
        for (int i = 0; i < 4; i++) step("run");
        chk("run/pc4", pc, 16'h0004);

        // flags := 000 -> 010 (Z), then jump via jctrl[2]
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 6'b000000, 16'h0000);
        step("flag_z");
        chk("flag_z/val", 16'(flags), 16'h0002);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'b001000, 16'h0040);
        step("jmp_z");
        chk("jmp_z/taken", 16'(taken), 16'h0001);
        chk("jmp_z/pc", pc, 16'h0040);
        idle();
        step("flush1");
        chk("flush1/flush", 16'(flush), 16'h0001);
        step("flush2");
        chk("flush2/flush", 16'(flush), 16'h0000);
        chk("flush2/pc", pc, 16'h0040);
        step("after");
        chk("after/pc", pc, 16'h0041);

        // flags := 101, mask[5]=0 -> not taken
        drive(1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 6'b000000, 16'h0000);
        step("flag_sc");
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'b111110, 16'h0099);
        step("nt");
        chk("nt/taken", 16'(taken), 16'h0000);

        // jump to FFFE and observe wrap
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'b000001, 16'hFFFE);
        step("jmp_wrap");
        idle();
        for (int i = 0; i < FLUSH_CYCLES; i++) step("wrap_fl");
        chk("wrap/fffe", pc, 16'hFFFE);
        step("wrap_ffff");
        step("wrap_0000");
        chk("wrap/0000", pc, 16'h0000);

        // stall inside FLUSH, with a jump request that must be ignored
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'b000001, 16'h0200);
        step("jmp_st");
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 6'b111111, 16'h0300);
        for (int i = 0; i < 3; i++) step("st_fl");
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'b111111, 16'h0300);
        step("st_fl4");
        chk("st_fl4/flush", 16'(flush), 16'h0001);
        chk("st_fl4/pc", pc, 16'h0200);
        step("st_fl5");
        chk("st_fl5/flush", 16'(flush), 16'h0000);

        // reset in the middle of a flush
        idle();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6'b000001, 16'h0500);
        step("jmp_rst");
        idle();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst_n = 1'b1;

        // same-edge flag write and jump: old flags 000 select jctrl[0], new flags 010 select jctrl[2]
        drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 6'b100000, 16'h0700);
        step("same_edge");
`ifdef BRANCH_FLAG_BYPASS_EN
        chk("same_edge/taken", 16'(taken), 16'h0000);
`else
        chk("same_edge/taken", 16'(taken), 16'h0001);
`endif
        idle();
        for (int i = 0; i < FLUSH_CYCLES; i++) step("se_fl");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 4),
                  6'($urandom_range(0, 63)),
                  16'($urandom));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Owns the program counter and the S/Z/C flag register for the 16-bit core.
- Sequences fetch addresses: increments the PC each cycle, resolves conditional jumps against the latched flags, and redirects the PC when a jump is taken.
- Drives a fixed-length pipeline flush after every taken jump.
- Sits between the ALU writeback (flag source), the decoder (jump request, 6-bit condition mask, target) and the instruction fetch port.

Parameters:
- PC_W, 16, width of the PC and jump target.
- RESET_VEC, 16'h0000, PC value after reset.
- FLUSH_CYCLES, 2, number of cycles o_flush is held after a taken jump; legal range 1..7.

Ports:
- i_clk, in, 1, clock; all state updates on the rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_stall, in, 1, freeze the PC and FSM for this cycle.
- i_flag_we, in, 1, latch flags from i_alu_res/i_alu_carry.
- i_alu_res, in, [0:15], ALU result; bit 0 is the sign bit.
- i_alu_carry, in, 1, ALU carry out.
- i_jmp_req, in, 1, decoder presents a conditional jump this cycle.
- i_jCtrl, in, [0:5], condition mask.
- i_jTarget, in, [0:PC_W-1], jump destination.
- o_pc, out, [0:PC_W-1], fetch address (registered).
- o_pc_valid, out, 1, o_pc is a live fetch address.
- o_flush, out, 1, downstream pipeline must discard in-flight instructions.
- o_taken, out, 1, one-cycle pulse: a jump was taken on the previous edge.
- o_flags, out, [0:2], registered {S,Z,C}.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_pc=RESET_VEC, o_flags=3'b000, o_pc_valid=1, o_flush=0, o_taken=0.
  - FSM=RUN, flush counter=0.
  - Deassertion takes effect on the next edge.
- Flag register, on an edge with i_flag_we=1:
  - S=i_alu_res[0]
  - Z=(i_alu_res==0)
  - C=i_alu_carry
  - Flags update regardless of i_stall and FSM state.
- Condition evaluation:
  - sel={S,Z,C} read from the registered flags, as an unsigned value 0..7.
  - mask={i_jCtrl[0..5],1'b0,1'b0}; mask index 0 is i_jCtrl[0].
  - cond=mask[sel]. sel 6 and 7 always give 0.
- FSM state RUN:
  - i_stall=1: hold o_pc, ignore i_jmp_req, o_taken=0.
  - i_stall=0, no request, or request with cond=0: o_pc<=o_pc+1, wrapping 16'hFFFF to 16'h0000.
  - i_stall=0, i_jmp_req=1, cond=1: o_pc<=i_jTarget, o_taken<=1, o_flush<=1, o_pc_valid<=0, counter<=FLUSH_CYCLES-1, go to FLUSH.
- FSM state FLUSH:
  - o_pc holds the target, o_flush=1, o_pc_valid=0, i_jmp_req ignored.
  - i_stall=1 freezes the counter.
  - Otherwise the counter decrements. When it is 0 on an edge: go to RUN, o_flush<=0, o_pc_valid<=1; o_pc stays at the target (no increment on that edge).
- o_taken is high for exactly one cycle per taken jump, and is 0 in every other cycle.
- Timing: a jump taken at edge N gives o_pc=target from N+1, o_flush high for cycles N+1 .. N+FLUSH_CYCLES, and the target is fetched valid at N+FLUSH_CYCLES+1.
- Simultaneous i_flag_we and i_jmp_req on the same edge: the condition uses the pre-edge flags (see the optional feature for the alternative).
- Reset asserted during FLUSH: immediately returns to the reset values above; the pending flush is abandoned.

Optional Feature:
- Macro: BRANCH_FLAG_BYPASS_EN.
- Defined: when i_flag_we=1 in the same cycle as i_jmp_req, sel is computed from the incoming i_alu_res/i_alu_carry instead of the registered flags. This removes the one-instruction compare-to-branch hazard.
- Not defined: sel always comes from the registered flags, as specified above.
- The flag register update itself is identical in both builds.

Test Plan:
- Reset release, no stall, 4 cycles, no jumps -> o_pc 0,1,2,3,4; o_pc_valid=1; o_flush=0.
- Flags written with res=16'h0000, C=0 (sel=010), then jmp_req with i_jCtrl=6'b001000, target 16'h0040 -> o_taken pulse; o_pc=16'h0040; o_flush high exactly 2 cycles; then 16'h0040 valid, then 16'h0041.
- Flags written with res=16'h8000, C=1 (sel=101), jmp_req with i_jCtrl=6'b111110 -> not taken (mask[5]=0); o_pc increments; o_flush stays 0.
- PC preloaded via jump to 16'hFFFE, then run 3 cycles -> o_pc FFFE, FFFF, 0000.
- Taken jump, then i_stall=1 for 3 cycles during FLUSH -> o_flush lasts 2+3 cycles; jmp_req during FLUSH ignored; o_pc stays at target throughout.
- i_rst_n pulled low mid-FLUSH -> o_pc=RESET_VEC, o_flush=0, o_flags=000 immediately, without waiting for a clock edge. Same-cycle flag write plus jump checked in both BRANCH_FLAG_BYPASS_EN builds: old flags vs. new flags decide the jump.
